// File: rtl/bcd_down_counter_pkg.sv
// Shared BCD constants and the nibble saturation helper for the down counter.
package bcd_pkg;
  localparam int       BCD_W    = 4;
  localparam bit [3:0] BCD_MAX  = 4'd9;
  localparam bit [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] bcd_sat(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction
endpackage

// File: rtl/bcd_down_counter_if.sv
// Control/data bundle of the BCD down counter: load/count controls in, count and flags out.
interface bcd_down_counter_if #(parameter int DIGITS = 2);
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic                  en;
  logic [4*DIGITS-1:0]   q;
  logic                  zero;
  logic                  bo;
  logic                  tc;

  modport master (output load, din, en, input q, zero, bo, tc);
  modport slave  (input load, din, en, output q, zero, bo, tc);
endinterface

// File: rtl/bcd_down_counter_digit_dn.sv
// One decade cell: saturating load, decrement on borrow-in, 0 -> 9 on borrow.
module bcd_digit_dn
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] d,
  input  logic       bin,
  output logic [3:0] q,
  output logic       bout
);
  logic [3:0] r_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_q <= BCD_ZERO;
    end else if (load) begin
      r_q <= bcd_sat(d);
    end else if (bin) begin
      r_q <= (r_q == BCD_ZERO) ? BCD_MAX : r_q - 4'd1;
    end
  end

  assign q    = r_q;
  assign bout = bin & (r_q == BCD_ZERO);
endmodule

// File: rtl/bcd_down_counter.sv
// Multi-decade BCD down counter with parallel load, wrap or auto-reload, borrow-out and tc pulse.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
)(
  input  logic               clk,
  input  logic               clr,
  bcd_down_counter_if.slave  bus
);
  localparam int W = BCD_W * DIGITS;

  logic [W-1:0]    r_reload;
  logic            r_tc;
  logic [W-1:0]    w_q;
  logic [W-1:0]    w_din_sat;
  logic [W-1:0]    w_cell_d;
  logic [DIGITS:0] w_borrow;
  logic            w_zero;
  logic            w_is_one;
  logic            w_wrap_reload;
  logic            w_cell_load;

  always_comb begin
    w_din_sat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_din_sat[BCD_W*i +: BCD_W] = bcd_sat(bus.din[BCD_W*i +: BCD_W]);
    end
  end

  assign w_zero        = (w_q == '0);
  assign w_is_one      = (w_q == W'(1));
  assign w_borrow[0]   = bus.en & ~bus.load;
  // On auto-reload the cells are reloaded instead of stepping 0 -> 9.
  assign w_wrap_reload = AUTO_RELOAD & w_borrow[0] & w_zero;
  assign w_cell_load   = bus.load | w_wrap_reload;
  assign w_cell_d      = bus.load ? w_din_sat : r_reload;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_dn u_digit (
      .clk  (clk),
      .clr  (clr),
      .load (w_cell_load),
      .d    (w_cell_d[BCD_W*g +: BCD_W]),
      .bin  (w_borrow[g]),
      .q    (w_q[BCD_W*g +: BCD_W]),
      .bout (w_borrow[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      if (bus.load) begin
        r_reload <= w_din_sat;
      end
      r_tc <= w_borrow[0] & w_is_one;
    end
  end

  assign bus.q    = w_q;
  assign bus.zero = w_zero;
  // A borrow through every decade is exactly en & zero & ~load.
  assign bus.bo   = w_borrow[DIGITS];
  assign bus.tc   = r_tc;
endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed plus random check of bcd_down_counter against an integer countdown model.
module tb_bcd_down_counter;
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  bcd_down_counter_if #(.DIGITS(2)) ifa ();
  bcd_down_counter_if #(.DIGITS(2)) ifb ();
  bcd_down_counter_if #(.DIGITS(1)) ifl ();
  bcd_down_counter_if #(.DIGITS(1)) ifh ();

  bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b0)) u_a (.clk(clk), .clr(clr), .bus(ifa.slave));
  bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b1)) u_b (.clk(clk), .clr(clr), .bus(ifb.slave));
  bcd_down_counter #(.DIGITS(1), .AUTO_RELOAD(1'b0)) u_l (.clk(clk), .clr(clr), .bus(ifl.slave));
  bcd_down_counter #(.DIGITS(1), .AUTO_RELOAD(1'b0)) u_h (.clk(clk), .clr(clr), .bus(ifh.slave));

  assign ifh.en = ifl.bo;

  int checks   = 0;
  int failures = 0;

  int m_val [2];
  int m_rel [2];
  bit m_tc  [2];
  int m_cv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [7:0] b);
    int n0, n1;
    n0 = int'(b[3:0]);
    n1 = int'(b[7:4]);
    if (n0 > 9) n0 = 9;
    if (n1 > 9) n1 = 9;
    return n1 * 10 + n0;
  endfunction

  function automatic logic [31:0] int2bcd(input int v);
    logic [31:0] r;
    r = '0;
    r[3:0] = 4'(v % 10);
    r[7:4] = 4'(v / 10);
    return r;
  endfunction

  task automatic model_step(input int k, input bit c, input bit ld, input logic [7:0] d, input bit e);
    if (!c) begin
      m_val[k] = 0; m_rel[k] = 0; m_tc[k] = 1'b0;
    end else if (ld) begin
      m_val[k] = bcd2int(d); m_rel[k] = m_val[k]; m_tc[k] = 1'b0;
    end else if (e) begin
      m_tc[k] = (m_val[k] == 1);
      if (m_val[k] == 0) m_val[k] = (k == 1) ? m_rel[k] : 99;
      else               m_val[k] = m_val[k] - 1;
    end else begin
      m_tc[k] = 1'b0;
    end
  endtask

  // Applies one cycle of stimulus to the two 2-digit counters and checks them.
  task automatic step(input bit c, input bit ld, input logic [7:0] d, input bit e);
    clr = c;
    ifa.load = ld; ifa.din = d; ifa.en = e;
    ifb.load = ld; ifb.din = d; ifb.en = e;
    #1;
    if (c) begin
      chk("zero_a", 32'(ifa.zero), 32'(m_val[0] == 0));
      chk("bo_a",   32'(ifa.bo),   32'(e && !ld && m_val[0] == 0));
      chk("zero_b", 32'(ifb.zero), 32'(m_val[1] == 0));
      chk("bo_b",   32'(ifb.bo),   32'(e && !ld && m_val[1] == 0));
    end
    model_step(0, c, ld, d, e);
    model_step(1, c, ld, d, e);
    @(posedge clk);
    #1;
    chk("q_a",  32'(ifa.q),  int2bcd(m_val[0]));
    chk("tc_a", 32'(ifa.tc), 32'(m_tc[0]));
    chk("q_b",  32'(ifb.q),  int2bcd(m_val[1]));
    chk("tc_b", 32'(ifb.tc), 32'(m_tc[1]));
  endtask

  task automatic cstep(input bit ld, input int val, input bit e);
    clr = 1'b1;
    ifl.load = ld; ifh.load = ld;
    ifl.din = 4'(val % 10); ifh.din = 4'(val / 10);
    ifl.en = e;
    #1;
    if (ld)     m_cv = val;
    else if (e) m_cv = (m_cv == 0) ? 99 : m_cv - 1;
    @(posedge clk);
    #1;
    chk("q_cascade", 32'({ifh.q, ifl.q}), int2bcd(m_cv));
  endtask

  initial begin
    bit         c, ld, e;
    logic [7:0] d;
    ifl.load = 1'b0; ifl.din = '0; ifl.en = 1'b0;
    ifh.load = 1'b0; ifh.din = '0;
    m_cv = 0;
    @(negedge clk);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h57, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

    step(1'b1, 1'b1, 8'h23, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

    step(1'b1, 1'b1, 8'h02, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

    step(1'b1, 1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

    step(1'b1, 1'b1, 8'hA7, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b1);

    step(1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 400; i++) begin
      c  = ($urandom % 40) != 0;
      ld = ($urandom % 8) == 0;
      e  = ($urandom % 4) != 0;
      d  = ($urandom % 2 == 0) ? 8'($urandom % 4) : 8'($urandom);
      step(c, ld, d, e);
    end

    cstep(1'b1, 10, 1'b0);
    for (int i = 0; i < 11; i++) cstep(1'b0, 0, 1'b1);
    cstep(1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
